ysyx_23060201_mem_arbiter: RTL and testbench
============================================

Name: ysyx_23060201_mem_arbiter

Overview:
- Sequences and shares the single core memory port between instruction fetch (IFU, read-only) and the execute-stage load/store path (LSU: EXU mem_ren/mem_wen, address, mask, data).
- One transaction in flight at a time; round-robin arbitration; valid/ready request handshake and single-pulse responses.
- A bus timeout guards against a hung memory.
- Sits between IFU/EXU and the memory/bus model.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, read/write data width
MASK_WIDTH, 8, byte-mask width. Codes: 0001/0011/1111 = byte/half/word; bit4 = sign-extend flag. Passed through untouched.
TIMEOUT, 255, cycles allowed in ISSUE+WAIT before an error response; 0 disables the timeout. Counter width is $clog2(TIMEOUT+1).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ifu_req_valid  in  1  fetch request
ifu_req_ready  out  1  fetch request accepted this cycle
ifu_addr  in  ADDR_WIDTH  fetch address
ifu_resp_valid  out  1  fetch response pulse
ifu_rdata  out  DATA_WIDTH  fetch data
ifu_resp_err  out  1  fetch error (timeout or memory error)
lsu_req_valid  in  1  load/store request
lsu_req_ready  out  1  load/store accepted this cycle
lsu_wen  in  1  1 = store, 0 = load
lsu_addr  in  ADDR_WIDTH  load/store address
lsu_wdata  in  DATA_WIDTH  store data
lsu_mask  in  MASK_WIDTH  byte mask / sign flag
lsu_resp_valid  out  1  load/store response pulse
lsu_rdata  out  DATA_WIDTH  load data; 0 for stores
lsu_resp_err  out  1  load/store error
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_wen  out  1  write enable
mem_addr  out  ADDR_WIDTH  address
mem_wdata  out  DATA_WIDTH  write data
mem_mask  out  MASK_WIDTH  mask
mem_resp_valid  in  1  memory response
mem_rdata  in  DATA_WIDTH  memory read data
mem_resp_err  in  1  memory error
busy  out  1  state != IDLE
owner  out  1  current/last grant: 0 = IFU, 1 = LSU

Behaviour:
- Reset (rst_n low, async):
  - State IDLE; all outputs 0; latched request fields 0; last_owner = IFU(0), so LSU wins the first tie; timeout counter 0.
  - Reset mid-transaction abandons it with no response pulse.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - Winner selection, combinational: only one valid -> that one. Both valid -> the requester != last_owner.
  - Winner's req_ready = 1 in the same cycle (loser's = 0). At the edge: latch addr/wdata/mask/wen (IFU: wen = 0, mask = 1111, wdata = 0); last_owner <= winner; go to ISSUE.
  - req_ready is never asserted outside IDLE.
- ISSUE:
  - mem_req_valid = 1, driven from the latched fields.
  - On mem_req_ready -> WAIT.
  - mem_resp_valid is ignored in this state.
- WAIT:
  - On mem_resp_valid, in the same cycle: owner's resp_valid = 1; rdata = mem_rdata for loads/fetches, 0 for stores; resp_err = mem_resp_err. Next state IDLE.
  - The other requester's resp outputs stay 0.
- Latency:
  - Request accepted at cycle T -> mem_req_valid first high at T+1.
  - Minimum accept-to-response is 2 cycles (ready at T+1, resp at T+2).
  - Next accept is possible in the cycle after the response.
- Responses are single-cycle pulses with no back-pressure; requesters must consume them.
- Timeout (TIMEOUT > 0):
  - Counter clears on entering ISSUE and increments each cycle in ISSUE or WAIT.
  - When the count equals TIMEOUT with no completion: owner resp_valid = 1, resp_err = 1, rdata = 0; go to IDLE.
  - If mem_resp_valid arrives in that same cycle, the real response wins (no error).
  - Stray mem_resp_valid in IDLE is ignored.
- Requests must hold valid and stable until ready. The arbiter does not check this; a deasserted valid before grant simply loses eligibility.
- owner output = last_owner register; busy is registered-state decoded.

Test Plan:
- Single IFU fetch of 0x8000_0000, mem_req_ready immediate, mem_resp_valid one cycle later with rdata 0x0000_0413 -> ifu_req_ready at T; mem_req_valid at T+1 with mem_wen 0 and mask 1111; ifu_resp_valid at T+2 with ifu_rdata 0x0000_0413; lsu_resp_valid stays 0.
- Store from LSU: addr 0x8000_1004, wdata 0xDEAD_BEEF, mask 00000011 -> mem_wen 1 with identical fields; lsu_resp_valid pulse with lsu_rdata 0.
- Both valid continuously after reset for 4 transactions -> grants in order LSU, IFU, LSU, IFU; owner toggles; no cycle has both req_ready high.
- Memory holds mem_req_ready 0, TIMEOUT = 8 -> after 8 cycles in ISSUE, ifu_resp_valid = 1 and ifu_resp_err = 1, rdata 0; state returns to IDLE; a later stray mem_resp_valid causes no pulse.
- Reset asserted while in WAIT -> all outputs 0 immediately (async); after release, a new LSU request is granted first and completes normally.
- Load with mem_resp_err = 1 and rdata 0x1234_5678 -> lsu_resp_err = 1 and lsu_rdata = 0x1234_5678 in the same cycle.

Source files
------------

// File: rtl/ysyx_23060201_mem_arbiter.sv
// Memory port arbiter: shares one memory port between IFU and LSU.
// Round-robin grant, one transaction in flight, bus timeout guard.
module ysyx_23060201_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    output logic                  ifu_resp_err,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_wen,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [MASK_WIDTH-1:0] lsu_mask,
    output logic                  lsu_resp_valid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  lsu_resp_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [MASK_WIDTH-1:0] mem_mask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp_err,
    output logic                  busy,
    output logic                  owner
);

    // A zero TIMEOUT still needs a legal one-bit counter.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT);
    localparam logic [MASK_WIDTH-1:0] WORD_MASK = MASK_WIDTH'(4'b1111);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  last_owner;
    logic                  lat_wen;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [MASK_WIDTH-1:0] lat_mask;
    logic [CW-1:0]         tmo_cnt;

    logic                  grant_lsu;
    logic                  accept;
    logic                  tmo_hit;
    logic                  done;
    logic                  resp_fire;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    // Winner selection: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant_lsu     = lsu_req_valid && (!ifu_req_valid || !last_owner);
        accept        = (state == IDLE) && (ifu_req_valid || lsu_req_valid);
        lsu_req_ready = (state == IDLE) && grant_lsu;
        ifu_req_ready = (state == IDLE) && ifu_req_valid && !grant_lsu;
    end

    // Completion decode: a real memory response beats a simultaneous timeout.
    always_comb begin
        done    = (state == WAIT) && mem_resp_valid;
        tmo_hit = (TIMEOUT > 0) && (state != IDLE) && (tmo_cnt == TMO_MAX);
        resp_fire = done || tmo_hit;
        resp_rdata = '0;
        resp_err   = 1'b0;
        if (done) begin
            resp_rdata = lat_wen ? '0 : mem_rdata;
            resp_err   = mem_resp_err;
        end else if (tmo_hit) begin
            resp_err = 1'b1;
        end
    end

    // Route the response pulse to the requester that owns the transaction.
    always_comb begin
        ifu_resp_valid = resp_fire && !last_owner;
        lsu_resp_valid = resp_fire && last_owner;
        ifu_rdata      = ifu_resp_valid ? resp_rdata : '0;
        ifu_resp_err   = ifu_resp_valid && resp_err;
        lsu_rdata      = lsu_resp_valid ? resp_rdata : '0;
        lsu_resp_err   = lsu_resp_valid && resp_err;
    end

    // Next-state logic and memory request strobe.
    always_comb begin
        state_nxt     = state;
        mem_req_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = ISSUE;
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                if (tmo_hit)            state_nxt = IDLE;
                else if (mem_req_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (resp_fire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Capture the granted request; fetches become word reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= 1'b0;
            lat_wen    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_mask   <= '0;
        end else if (accept) begin
            last_owner <= grant_lsu;
            if (grant_lsu) begin
                lat_wen   <= lsu_wen;
                lat_addr  <= lsu_addr;
                lat_wdata <= lsu_wdata;
                lat_mask  <= lsu_mask;
            end else begin
                lat_wen   <= 1'b0;
                lat_addr  <= ifu_addr;
                lat_wdata <= '0;
                lat_mask  <= WORD_MASK;
            end
        end
    end

    // Timeout counter: cleared on grant, counts while a transaction is open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if ((TIMEOUT > 0) && (state != IDLE) && !resp_fire) begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end
    end

    assign mem_wen   = lat_wen;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign mem_mask  = lat_mask;
    assign busy      = (state != IDLE);
    assign owner     = last_owner;

endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// Directed bench for the memory arbiter.
// Inputs change just after posedge; outputs are checked at negedge.
module tb_ysyx_23060201_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        ifu_resp_err;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen;
    logic [31:0] lsu_addr, lsu_wdata;
    logic [7:0]  lsu_mask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        lsu_resp_err;
    logic        mem_req_valid, mem_req_ready, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [7:0]  mem_mask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        mem_resp_err;
    logic        busy, owner;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_23060201_mem_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MASK_WIDTH(8), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid),
        .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_wen(lsu_wen), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_mask(lsu_mask), .lsu_resp_valid(lsu_resp_valid),
        .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_mask(mem_mask), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
        .busy(busy), .owner(owner)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ifu_req_valid = 0; ifu_addr = 0;
        lsu_req_valid = 0; lsu_wen = 0; lsu_addr = 0;
        lsu_wdata = 0; lsu_mask = 0;
        mem_req_ready = 0; mem_resp_valid = 0;
        mem_rdata = 0; mem_resp_err = 0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_mreq", mem_req_valid, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_mmask", mem_mask, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single IFU fetch
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1;
        @(negedge clk);
        chk("f_ifu_rdy", ifu_req_ready, 1);
        chk("f_lsu_rdy", lsu_req_ready, 0);
        chk("f_mreq_T", mem_req_valid, 0);
        tick();
        ifu_req_valid = 0;
        @(negedge clk);
        chk("f_mreq", mem_req_valid, 1);
        chk("f_maddr", mem_addr, 32'h8000_0000);
        chk("f_mwen", mem_wen, 0);
        chk("f_mmask", mem_mask, 32'h0F);
        chk("f_busy", busy, 1);
        chk("f_owner", owner, 0);
        tick();
        mem_resp_valid = 1; mem_rdata = 32'h0000_0413;
        @(negedge clk);
        chk("f_rv", ifu_resp_valid, 1);
        chk("f_rdata", ifu_rdata, 32'h0000_0413);
        chk("f_rerr", ifu_resp_err, 0);
        chk("f_lsu_rv", lsu_resp_valid, 0);
        tick();
        mem_resp_valid = 0;
        @(negedge clk);
        chk("f_idle", busy, 0);
        chk("f_rv_off", ifu_resp_valid, 0);
        tick();

        // LSU store
        lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1004;
        lsu_wdata = 32'hDEAD_BEEF; lsu_mask = 8'h03;
        @(negedge clk);
        chk("s_lsu_rdy", lsu_req_ready, 1);
        chk("s_ifu_rdy", ifu_req_ready, 0);
        tick();
        lsu_req_valid = 0;
        @(negedge clk);
        chk("s_mreq", mem_req_valid, 1);
        chk("s_mwen", mem_wen, 1);
        chk("s_maddr", mem_addr, 32'h8000_1004);
        chk("s_mwdata", mem_wdata, 32'hDEAD_BEEF);
        chk("s_mmask", mem_mask, 32'h03);
        chk("s_owner", owner, 1);
        tick();
        mem_resp_valid = 1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("s_rv", lsu_resp_valid, 1);
        chk("s_rdata", lsu_rdata, 0);
        chk("s_ifu_rv", ifu_resp_valid, 0);
        tick();
        mem_resp_valid = 0; lsu_wen = 0;

        // Round-robin after a fresh reset
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        tick();
        chk("rr_owner0", owner, 0);
        ifu_req_valid = 1; ifu_addr = 32'h0000_00A0;
        lsu_req_valid = 1; lsu_addr = 32'h0000_00B0; lsu_mask = 8'h0F;
        mem_req_ready = 1;
        for (int i = 0; i < 4; i++) begin
            logic el;
            el = (i % 2 == 0);
            @(negedge clk);
            chk($sformatf("rr%0d_lrdy", i), lsu_req_ready, el);
            chk($sformatf("rr%0d_irdy", i), ifu_req_ready, !el);
            tick();
            @(negedge clk);
            chk($sformatf("rr%0d_own", i), owner, el);
            chk($sformatf("rr%0d_addr", i), mem_addr,
                el ? 32'h0000_00B0 : 32'h0000_00A0);
            tick();
            mem_resp_valid = 1; mem_rdata = i;
            @(negedge clk);
            chk($sformatf("rr%0d_lrv", i), lsu_resp_valid, el);
            chk($sformatf("rr%0d_irv", i), ifu_resp_valid, !el);
            tick();
            mem_resp_valid = 0;
        end
        ifu_req_valid = 0; lsu_req_valid = 0;

        // Timeout with memory never ready
        ifu_req_valid = 1; ifu_addr = 32'h0000_00C0; mem_req_ready = 0;
        @(negedge clk);
        chk("t_rdy", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 0; mem_rdata = 32'hDEAD_DEAD;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("t_wait%0d", k), {mem_req_valid, ifu_resp_valid}, 2);
            tick();
        end
        @(negedge clk);
        chk("t_rv", ifu_resp_valid, 1);
        chk("t_err", ifu_resp_err, 1);
        chk("t_rdata", ifu_rdata, 0);
        tick();
        @(negedge clk);
        chk("t_idle", busy, 0);
        tick();
        mem_resp_valid = 1;
        @(negedge clk);
        chk("t_stray_i", ifu_resp_valid, 0);
        chk("t_stray_l", lsu_resp_valid, 0);
        tick();
        mem_resp_valid = 0;

        // Reset in WAIT
        ifu_req_valid = 1; ifu_addr = 32'h0000_00E0; mem_req_ready = 1;
        @(negedge clk);
        chk("r_rdy", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 0;
        tick();
        mem_req_ready = 0;
        @(negedge clk);
        chk("r_busy", busy, 1);
        #1;
        rst_n = 0; mem_resp_valid = 1;
        #1;
        chk("r_busy0", busy, 0);
        chk("r_mreq0", mem_req_valid, 0);
        chk("r_maddr0", mem_addr, 0);
        chk("r_irv0", ifu_resp_valid, 0);
        chk("r_lrv0", lsu_resp_valid, 0);
        mem_resp_valid = 0;
        @(negedge clk);
        rst_n = 1;
        tick();
        ifu_req_valid = 1; ifu_addr = 32'h0000_00E4;
        lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h0000_00F0;
        mem_req_ready = 1;
        @(negedge clk);
        chk("r2_lrdy", lsu_req_ready, 1);
        chk("r2_irdy", ifu_req_ready, 0);
        tick();
        ifu_req_valid = 0; lsu_req_valid = 0;
        @(negedge clk);
        chk("r2_addr", mem_addr, 32'h0000_00F0);
        tick();
        mem_resp_valid = 1; mem_rdata = 32'h55AA_55AA;
        @(negedge clk);
        chk("r2_lrv", lsu_resp_valid, 1);
        chk("r2_rdata", lsu_rdata, 32'h55AA_55AA);
        tick();
        mem_resp_valid = 0;

        // Load with memory error
        lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h0000_0100;
        lsu_mask = 8'h11;
        @(negedge clk);
        chk("e_rdy", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 0;
        @(negedge clk);
        chk("e_mmask", mem_mask, 32'h11);
        tick();
        mem_resp_valid = 1; mem_resp_err = 1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("e_rv", lsu_resp_valid, 1);
        chk("e_err", lsu_resp_err, 1);
        chk("e_rdata", lsu_rdata, 32'h1234_5678);
        chk("e_ifu_err", ifu_resp_err, 0);
        tick();
        mem_resp_valid = 0; mem_resp_err = 0;
        @(negedge clk);
        chk("e_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
